// File: rtl/button_ctrl_pkg.sv
// Shared types for the button controller: the per-key debounce state and its output decode.
package button_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_PEND = 2'd1,
        PRESSED    = 2'd2,
        REL_PEND   = 2'd3
    } button_state_t;

    function automatic logic state_pressed(input button_state_t s);
        return (s == PRESSED) || (s == REL_PEND);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// One key: two-flop synchronizer on the active-low raw input, then a tick-counted debounce FSM.
module button_debounce
    import button_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = 16
) (
    input  logic          clk28,
    input  logic          rst,
    input  logic          key_n_raw,
    input  logic          tick,
    output button_state_t state
);

    localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);

    logic [1:0]       sync_n;
    logic             level;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] cnt_inc;
    button_state_t    state_next;

    // Synchronizer flops reset to the released (high) level so reset never looks like a press.
    always_ff @(posedge clk28) begin
        if (rst) begin
            sync_n <= 2'b11;
        end else begin
            sync_n <= {sync_n[0], key_n_raw};
        end
    end

    assign level   = ~sync_n[1];
    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk28) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (level) begin
                    state_next = PRESS_PEND;
                    cnt_next   = '0;
                end
            end
            PRESS_PEND: begin
                if (!level) begin
                    state_next = IDLE;
                end else if (tick) begin
                    cnt_next = cnt_inc;
                    if (cnt_inc >= CNT_W'(DEBOUNCE_TICKS)) begin
                        state_next = PRESSED;
                    end
                end
            end
            PRESSED: begin
                if (!level) begin
                    state_next = REL_PEND;
                    cnt_next   = '0;
                end
            end
            REL_PEND: begin
                if (level) begin
                    state_next = PRESSED;
                end else if (tick) begin
                    cnt_next = cnt_inc;
                    if (cnt_inc >= CNT_W'(DEBOUNCE_TICKS)) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/button_ctrl.sv
// Magic/pause key controller: shared tick prescaler, two debouncers, optional long-press reboot.
// Long-press detection is compiled in with `define BUTTON_LONGPRESS_EN.
module button_ctrl
    import button_ctrl_pkg::*;
#(
    parameter int TICK_DIV       = 28000,
    parameter int DEBOUNCE_TICKS = 16,
    parameter int LONG_TICKS     = 2000
) (
    input  logic clk28,
    input  logic rst,
    input  logic magic_n_raw,
    input  logic pause_n_raw,
    output logic magic_button,
    output logic pause_button,
    output logic reboot_req,
    output logic tick
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PRE_W-1:0] pre_cnt;
    button_state_t    magic_state;
    button_state_t    pause_state;

    always_ff @(posedge clk28) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    assign tick = (pre_cnt == PRE_W'(TICK_DIV - 1));

    button_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_magic (
        .clk28     (clk28),
        .rst       (rst),
        .key_n_raw (magic_n_raw),
        .tick      (tick),
        .state     (magic_state)
    );

    button_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_pause (
        .clk28     (clk28),
        .rst       (rst),
        .key_n_raw (pause_n_raw),
        .tick      (tick),
        .state     (pause_state)
    );

    assign magic_button = state_pressed(magic_state);
    assign pause_button = state_pressed(pause_state);

`ifdef BUTTON_LONGPRESS_EN
    localparam int HOLD_W = $clog2(LONG_TICKS + 1);

    logic [HOLD_W-1:0] hold_cnt;

    // Saturating at LONG_TICKS makes the LONG_TICKS-1 -> LONG_TICKS step, and so the pulse, happen once per hold.
    always_ff @(posedge clk28) begin
        if (rst || !magic_button) begin
            hold_cnt <= '0;
        end else if (tick && (hold_cnt != HOLD_W'(LONG_TICKS))) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign reboot_req = !rst && tick && magic_button && (hold_cnt == HOLD_W'(LONG_TICKS - 1));
`else
    // LONG_TICKS stays referenced so both builds share one parameter list.
    assign reboot_req = 1'b0 & (LONG_TICKS != 0);
`endif

endmodule

// File: tb/tb_button_ctrl.sv
// Directed bench for button_ctrl: expected output events (kind + clock edge) are queued by the driver
// and popped by an independent monitor whenever an output changes or reboot_req pulses.
module tb_button_ctrl;

    localparam int TICK_DIV = 4;
    localparam int DB       = 3;
    localparam int LT       = 5;
    localparam int W        = 20;

    localparam logic [3:0] EV_MR = 4'd1;
    localparam logic [3:0] EV_MF = 4'd2;
    localparam logic [3:0] EV_PR = 4'd3;
    localparam logic [3:0] EV_PF = 4'd4;
    localparam logic [3:0] EV_RB = 4'd5;

`ifdef BUTTON_LONGPRESS_EN
    localparam int RB_PER_HOLD = 1;
`else
    localparam int RB_PER_HOLD = 0;
`endif

    logic clk28       = 1'b0;
    logic rst         = 1'b1;
    logic magic_n_raw = 1'b1;
    logic pause_n_raw = 1'b1;
    logic magic_button;
    logic pause_button;
    logic reboot_req;
    logic tick;

    button_ctrl #(
        .TICK_DIV       (TICK_DIV),
        .DEBOUNCE_TICKS (DB),
        .LONG_TICKS     (LT)
    ) dut (
        .clk28        (clk28),
        .rst          (rst),
        .magic_n_raw  (magic_n_raw),
        .pause_n_raw  (pause_n_raw),
        .magic_button (magic_button),
        .pause_button (pause_button),
        .reboot_req   (reboot_req),
        .tick         (tick)
    );

    // ---------------- clock / edge counter ----------------
    always #5 clk28 = ~clk28;

    int ecount = 0;
    always @(posedge clk28) ecount <= ecount + 1;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   rb_seen  = 0;
    int   tick_org = 0;
    bit   mon_en   = 1'b0;
    logic prev_m   = 1'b0;
    logic prev_p   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic observe(input logic [3:0] kind);
        logic [W-1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d at edge %0d, none expected", kind, ecount);
        end else begin
            e = exp_q.pop_front();
            if (e !== {kind, ecount[15:0]}) begin
                errors++;
                $display("FAIL event: got kind %0d edge %0d expected kind %0d edge %0d",
                         kind, ecount, e[19:16], e[15:0]);
            end
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk28) begin
        if (mon_en) begin
            if (magic_button !== prev_m) observe(magic_button ? EV_MR : EV_MF);
            if (pause_button !== prev_p) observe(pause_button ? EV_PR : EV_PF);
            if (reboot_req !== 1'b0) begin
                rb_seen <= rb_seen + 1;
                observe(EV_RB);
            end
            prev_m <= magic_button;
            prev_p <= pause_button;
        end
    end

    // ---------------- driver helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk28);
    endtask

    task automatic wait_until(input int target);
        while (ecount < target) cyc(1);
    endtask

    task automatic push(input logic [3:0] kind, input int e_idx);
        exp_q.push_back({kind, e_idx[15:0]});
    endtask

    // n-th prescaler tick edge strictly after edge e; tick edges are tick_org + k*TICK_DIV, k >= 1.
    function automatic int next_tick(input int e, input int n);
        int first;
        first = tick_org + TICK_DIV * (((e - tick_org) / TICK_DIV) + 1);
        return first + TICK_DIV * (n - 1);
    endfunction

    task automatic drain(input string name);
        int budget;
        budget = 400;
        while ((exp_q.size() != 0) && (budget > 0)) begin
            cyc(1);
            budget--;
        end
        cyc(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d pending events expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int j;
        int p;
        int r;
        int rb_before;

        // Reset state
        rst = 1'b1;
        cyc(3);
        check("rst_magic", magic_button, 0);
        check("rst_pause", pause_button, 0);
        check("rst_reboot", reboot_req, 0);
        check("rst_tick", tick, 0);
        rst      = 1'b0;
        tick_org = ecount;
        mon_en   = 1'b1;

        // Prescaler period
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            check("tick_phase", tick, (((ecount - tick_org) % TICK_DIV) == TICK_DIV - 1) ? 1 : 0);
        end

        // Clean magic press and release
        magic_n_raw = 1'b0;
        j = ecount;
        p = next_tick(j + 3, DB);
        push(EV_MR, p);
        wait_until(p + 2 * TICK_DIV);
        magic_n_raw = 1'b1;
        j = ecount;
        push(EV_MF, next_tick(j + 3, DB));
        drain("clean_press");

        // Bounce: 1-tick low pulses never qualify
        for (int i = 0; i < 5; i++) begin
            magic_n_raw = 1'b0;
            cyc(TICK_DIV);
            magic_n_raw = 1'b1;
            cyc(TICK_DIV);
            check("bounce_level", magic_button, 0);
        end
        cyc(10);
        drain("bounce");

        // Long hold of 20 ticks
        rb_before = rb_seen;
        magic_n_raw = 1'b0;
        j = ecount;
        p = next_tick(j + 3, DB);
        push(EV_MR, p);
`ifdef BUTTON_LONGPRESS_EN
        push(EV_RB, p + LT * TICK_DIV - 1);
`endif
        wait_until(p + 20 * TICK_DIV);
        magic_n_raw = 1'b1;
        j = ecount;
        push(EV_MF, next_tick(j + 3, DB));
        drain("long_hold");
        check("long_hold_reboot_count", rb_seen - rb_before, RB_PER_HOLD);

        // Simultaneous press; pause held on alone afterwards
        rb_before = rb_seen;
        magic_n_raw = 1'b0;
        pause_n_raw = 1'b0;
        j = ecount;
        p = next_tick(j + 3, DB);
        push(EV_MR, p);
        push(EV_PR, p);
`ifdef BUTTON_LONGPRESS_EN
        push(EV_RB, p + LT * TICK_DIV - 1);
`endif
        wait_until(p + 6 * TICK_DIV);
        magic_n_raw = 1'b1;
        j = ecount;
        push(EV_MF, next_tick(j + 3, DB));
        wait_until(p + 16 * TICK_DIV);
        pause_n_raw = 1'b1;
        j = ecount;
        push(EV_PF, next_tick(j + 3, DB));
        drain("dual_press");
        check("dual_reboot_count", rb_seen - rb_before, RB_PER_HOLD);

        // Reset during a 4-tick hold, key kept down through and after reset
        rb_before = rb_seen;
        magic_n_raw = 1'b0;
        j = ecount;
        p = next_tick(j + 3, DB);
        push(EV_MR, p);
        wait_until(p + 4 * TICK_DIV);
        rst = 1'b1;
        push(EV_MF, p + 4 * TICK_DIV + 1);
        cyc(1);
        check("midrst_magic", magic_button, 0);
        check("midrst_pause", pause_button, 0);
        check("midrst_reboot", reboot_req, 0);
        check("midrst_tick", tick, 0);
        rst      = 1'b0;
        r        = ecount;
        tick_org = r;
        p = next_tick(r + 3, DB);
        push(EV_MR, p);
        wait_until(p + 2 * TICK_DIV);
        magic_n_raw = 1'b1;
        j = ecount;
        push(EV_MF, next_tick(j + 3, DB));
        drain("mid_reset");
        check("midrst_reboot_count", rb_seen - rb_before, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
